// File: rtl/regs_file.sv
// Integer register file x0..x31: two combinational read ports with write-through bypass,
// a registered debug read/write port that yields to core writes, and a committed-write counter.
module regs_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] reg1_raddr_i,
    input  logic [ADDR_W-1:0] reg2_raddr_i,
    output logic [DATA_W-1:0] reg1_rdata_o,
    output logic [DATA_W-1:0] reg2_rdata_o,
    input  logic [ADDR_W-1:0] reg_waddr_i,
    input  logic [DATA_W-1:0] reg_wdata_i,
    input  logic              reg_wen_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    input  logic              dbg_we_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_wdrop_o,
    output logic [CNT_W-1:0]  wr_cnt_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              core_we;
    logic              dbg_we;
    logic              dbg_collide;
    logic [DATA_W-1:0] dbg_view;

    assign core_we     = reg_wen_i && (reg_waddr_i != '0);
    assign dbg_we      = dbg_we_i && (dbg_addr_i != '0);
    assign dbg_collide = dbg_we && core_we && (dbg_addr_i == reg_waddr_i);

    // Entry 0 never matches a qualified write, so it stays at its reset value of zero.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs[g] <= '0;
            end else if (core_we && (reg_waddr_i == IDX)) begin
                regs[g] <= reg_wdata_i;
            end else if (dbg_we && (dbg_addr_i == IDX)) begin
                regs[g] <= dbg_wdata_i;
            end
        end
    end

    // Core write-back is visible in the same cycle; debug write data never is.
    assign reg1_rdata_o = (reg1_raddr_i == '0) ? '0 :
                          (core_we && (reg_waddr_i == reg1_raddr_i)) ? reg_wdata_i :
                          regs[reg1_raddr_i];
    assign reg2_rdata_o = (reg2_raddr_i == '0) ? '0 :
                          (core_we && (reg_waddr_i == reg2_raddr_i)) ? reg_wdata_i :
                          regs[reg2_raddr_i];
    assign dbg_view     = (dbg_addr_i == '0) ? '0 :
                          (core_we && (reg_waddr_i == dbg_addr_i)) ? reg_wdata_i :
                          regs[dbg_addr_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata_o <= '0;
            dbg_wdrop_o <= 1'b0;
            wr_cnt_o    <= '0;
        end else begin
            dbg_rdata_o <= dbg_view;
            dbg_wdrop_o <= dbg_collide;
            if (core_we) begin
                wr_cnt_o <= wr_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regs_file.sv
// Self-checking bench for regs_file: directed scenarios plus randomized traffic against
// an array-based model of the register file, debug port and write counter.
module tb_regs_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] reg1_raddr, reg2_raddr, reg_waddr, dbg_addr;
    logic [DATA_W-1:0] reg1_rdata, reg2_rdata, reg_wdata, dbg_wdata, dbg_rdata;
    logic              reg_wen, dbg_we, dbg_wdrop;
    logic [CNT_W-1:0]  wr_cnt;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] model_regs [32];
    logic [DATA_W-1:0] exp_dbg;
    logic              exp_drop;
    logic [CNT_W-1:0]  exp_cnt;

    regs_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg1_raddr_i (reg1_raddr),
        .reg2_raddr_i (reg2_raddr),
        .reg1_rdata_o (reg1_rdata),
        .reg2_rdata_o (reg2_rdata),
        .reg_waddr_i  (reg_waddr),
        .reg_wdata_i  (reg_wdata),
        .reg_wen_i    (reg_wen),
        .dbg_addr_i   (dbg_addr),
        .dbg_wdata_i  (dbg_wdata),
        .dbg_we_i     (dbg_we),
        .dbg_rdata_o  (dbg_rdata),
        .dbg_wdrop_o  (dbg_wdrop),
        .wr_cnt_o     (wr_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (reg_wen && reg_waddr == a) return reg_wdata;
        return model_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        exp_dbg  = '0;
        exp_drop = 1'b0;
        exp_cnt  = '0;
    endtask

    // driver tasks
    task automatic idle_inputs();
        reg_wen   = 1'b0;
        reg_waddr = '0;
        reg_wdata = '0;
        dbg_we    = 1'b0;
        dbg_addr  = '0;
        dbg_wdata = '0;
    endtask

    // Advance one clock; the model commits what the inputs ask for at this edge.
    task automatic tick();
        logic [DATA_W-1:0] nxt_dbg;
        logic              drop;
        nxt_dbg = model_read(dbg_addr);
        drop = dbg_we && dbg_addr != 0 && reg_wen && reg_waddr == dbg_addr;
        if (dbg_we && dbg_addr != 0 && !drop) model_regs[dbg_addr] = dbg_wdata;
        if (reg_wen && reg_waddr != 0) begin
            model_regs[reg_waddr] = reg_wdata;
            exp_cnt = exp_cnt + 1'b1;
        end
        exp_dbg  = nxt_dbg;
        exp_drop = drop;
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        reg_wen = 1'b1; reg_waddr = a; reg_wdata = d;
        tick();
        reg_wen = 1'b0;
    endtask

    // tests
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        reg1_raddr = '0;
        reg2_raddr = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            reg1_raddr = ADDR_W'(i);
            reg2_raddr = ADDR_W'(31 - i);
            dbg_addr   = ADDR_W'(i);
            @(posedge clk);
            #1;
            total++;
            if (reg1_rdata !== 0 || reg2_rdata !== 0 || dbg_rdata !== 0) begin
                bad++;
                $display("FAIL reset_read idx=%0d got r1=%h r2=%h dbg=%h want 0", i, reg1_rdata, reg2_rdata, dbg_rdata);
            end
        end
        total++;
        if (wr_cnt !== 0 || dbg_wdrop !== 0) begin
            bad++;
            $display("FAIL reset_cnt got cnt=%0d drop=%b want 0/0", wr_cnt, dbg_wdrop);
        end
        rst_n = 1'b1;
        dbg_addr = '0;
        tick();
    endtask

    task automatic test_write_read();
        core_write(5'd5, 32'hDEADBEEF);
        reg1_raddr = 5'd5;
        #1;
        total++;
        if (reg1_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_read got %h want deadbeef", reg1_rdata);
        end
        total++;
        if (wr_cnt !== 8'd1) begin
            bad++;
            $display("FAIL write_cnt got %0d want 1", wr_cnt);
        end
    endtask

    task automatic test_x0();
        reg_wen = 1'b1; reg_waddr = '0; reg_wdata = 32'h12345678;
        dbg_we = 1'b1; dbg_addr = '0; dbg_wdata = 32'hCAFEF00D;
        reg1_raddr = '0; reg2_raddr = '0;
        #1;
        total++;
        if (reg1_rdata !== 0 || reg2_rdata !== 0) begin
            bad++;
            $display("FAIL x0_bypass got r1=%h r2=%h want 0", reg1_rdata, reg2_rdata);
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if (reg1_rdata !== 0 || reg2_rdata !== 0 || dbg_rdata !== 0) begin
            bad++;
            $display("FAIL x0_after got r1=%h r2=%h dbg=%h want 0", reg1_rdata, reg2_rdata, dbg_rdata);
        end
        total++;
        if (wr_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL x0_cnt got %0d want %0d", wr_cnt, exp_cnt);
        end
    endtask

    task automatic test_bypass();
        core_write(5'd7, 32'h1);
        reg_wen = 1'b1; reg_waddr = 5'd7; reg_wdata = 32'hA5A5A5A5;
        reg1_raddr = 5'd7; reg2_raddr = 5'd7;
        #1;
        total++;
        if (reg1_rdata !== 32'hA5A5A5A5 || reg2_rdata !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL bypass_same got r1=%h r2=%h want a5a5a5a5", reg1_rdata, reg2_rdata);
        end
        tick();
        reg_wen = 1'b0;
        #1;
        total++;
        if (reg1_rdata !== 32'hA5A5A5A5 || reg2_rdata !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL bypass_after got r1=%h r2=%h want a5a5a5a5", reg1_rdata, reg2_rdata);
        end
    endtask

    task automatic test_collision();
        reg_wen = 1'b1; reg_waddr = 5'd9; reg_wdata = 32'h11;
        dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h22;
        tick();
        idle_inputs();
        reg1_raddr = 5'd9;
        #1;
        total++;
        if (dbg_wdrop !== 1'b1 || reg1_rdata !== 32'h11) begin
            bad++;
            $display("FAIL collide_same got drop=%b x9=%h want 1/11", dbg_wdrop, reg1_rdata);
        end
        reg_wen = 1'b1; reg_waddr = 5'd9; reg_wdata = 32'h33;
        dbg_we = 1'b1; dbg_addr = 5'd10; dbg_wdata = 32'h22;
        tick();
        idle_inputs();
        reg1_raddr = 5'd10;
        reg2_raddr = 5'd9;
        #1;
        total++;
        if (dbg_wdrop !== 1'b0 || reg1_rdata !== 32'h22 || reg2_rdata !== 32'h33) begin
            bad++;
            $display("FAIL collide_diff got drop=%b x10=%h x9=%h want 0/22/33", dbg_wdrop, reg1_rdata, reg2_rdata);
        end
        dbg_addr = 5'd10;
        tick();
        total++;
        if (dbg_rdata !== 32'h22) begin
            bad++;
            $display("FAIL dbg_read got %h want 22", dbg_rdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic narrow;
            narrow = ($urandom_range(0, 1) == 1);
            reg_wen    = ($urandom_range(0, 3) != 0);
            reg_waddr  = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
            reg_wdata  = $urandom;
            dbg_we     = ($urandom_range(0, 2) == 0);
            dbg_addr   = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
            dbg_wdata  = $urandom;
            reg1_raddr = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
            reg2_raddr = ADDR_W'($urandom);
            #1;
            total++;
            if (reg1_rdata !== model_read(reg1_raddr) || reg2_rdata !== model_read(reg2_raddr)) begin
                bad++;
                $display("FAIL rand_read n=%0d got r1=%h r2=%h want %h %h", n, reg1_rdata, reg2_rdata,
                         model_read(reg1_raddr), model_read(reg2_raddr));
            end
            tick();
            total++;
            if (dbg_rdata !== exp_dbg || dbg_wdrop !== exp_drop || wr_cnt !== exp_cnt) begin
                bad++;
                $display("FAIL rand_regd n=%0d got dbg=%h drop=%b cnt=%0d want %h %b %0d", n, dbg_rdata,
                         dbg_wdrop, wr_cnt, exp_dbg, exp_drop, exp_cnt);
            end
        end
        idle_inputs();
    endtask

    task automatic test_counter_wrap();
        int guard;
        guard = 0;
        while (exp_cnt != {CNT_W{1'b1}} && guard < 600) begin
            core_write(ADDR_W'($urandom_range(1, 31)), $urandom);
            guard++;
        end
        total++;
        if (wr_cnt !== {CNT_W{1'b1}}) begin
            bad++;
            $display("FAIL cnt_full got %0d want %0d", wr_cnt, {CNT_W{1'b1}});
        end
        core_write(5'd12, 32'h5);
        total++;
        if (wr_cnt !== 0) begin
            bad++;
            $display("FAIL cnt_wrap got %0d want 0", wr_cnt);
        end
    endtask

    task automatic test_async_reset();
        core_write(5'd3, 32'hBADC0DE);
        reg_wen = 1'b1; reg_waddr = 5'd3; reg_wdata = 32'h44;
        #2;
        rst_n = 1'b0;
        model_reset();
        reg_wen = 1'b0;
        reg1_raddr = 5'd3;
        dbg_addr = 5'd3;
        #1;
        total++;
        if (reg1_rdata !== 0 || wr_cnt !== 0 || dbg_rdata !== 0) begin
            bad++;
            $display("FAIL async_clear got x3=%h cnt=%0d dbg=%h want 0", reg1_rdata, wr_cnt, dbg_rdata);
        end
        // An edge inside reset must not commit anything.
        reg_wen = 1'b1; reg_wdata = 32'h55;
        @(posedge clk);
        #1;
        reg_wen = 1'b0;
        #1;
        total++;
        if (reg1_rdata !== 0 || wr_cnt !== 0) begin
            bad++;
            $display("FAIL reset_hold got x3=%h cnt=%0d want 0", reg1_rdata, wr_cnt);
        end
        rst_n = 1'b1;
        core_write(5'd3, 32'h77);
        #1;
        total++;
        if (reg1_rdata !== 32'h77 || wr_cnt !== 8'd1) begin
            bad++;
            $display("FAIL first_write got x3=%h cnt=%0d want 77 1", reg1_rdata, wr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_collision();
        test_random();
        test_counter_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "time limit");
    end

endmodule
